// File: rtl/perceptron_trainer.sv
// -----------------------------------------------------------------------------
// perceptron_trainer
//
// Training sequencer for a single-neuron perceptron. It holds a small labelled
// sample table and presents one sample at a time to the perceptron, together
// with the desired output. It counts misclassifications in each epoch and
// repeats epochs until an epoch has no errors or the epoch limit is reached.
// It also owns the perceptron's reset, so the weights can be restored at start.
//
// Optional feature: define PERCEPTRON_TRAINER_ERRLOG_EN to add err_valid and
// first_err_addr. These report whether the last completed epoch had an error,
// and the index of its first mismatching sample.
//
// Ports
//   clk, reset       clock; asynchronous active-low reset
//   wr_en/addr/data  sample table write port (accepted in IDLE only).
//                    Data layout: [3:0] in1, [7:4] in2, [14:8] in3, [15] desired
//   num_samples      number of table entries used (latched at start)
//   clear_weights    pulse p_rst_n low for one cycle before the first epoch
//   start            single-cycle start request
//   busy, done       run in progress; one-cycle pulse when the run finishes
//   converged        the last run ended on an error-free epoch
//   epoch_count      epochs completed in the current or last run
//   err_count        misclassifications in the most recently completed epoch
//   p_in1..3         registered perceptron inputs
//   p_desired        registered desired output
//   p_rst_n          perceptron reset
//   p_out            registered output of the perceptron
// -----------------------------------------------------------------------------
module perceptron_trainer #(
  parameter int DEPTH      = 8,
  parameter int AW         = 3,
  parameter int SETTLE     = 2,
  parameter int MAX_EPOCHS = 100
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic [AW:0]   num_samples,
  input  logic          clear_weights,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          converged,
  output logic [7:0]    epoch_count,
  output logic [AW:0]   err_count,
`ifdef PERCEPTRON_TRAINER_ERRLOG_EN
  output logic          err_valid,
  output logic [AW-1:0] first_err_addr,
`endif
  output logic [3:0]    p_in1,
  output logic [3:0]    p_in2,
  output logic [6:0]    p_in3,
  output logic          p_desired,
  output logic          p_rst_n,
  input  logic          p_out
);

  localparam int CW = AW + 1;
  // The sample window is LOAD + (SETTLE-2) HOLD cycles + CHECK.
  localparam int HW = (SETTLE > 2) ? $clog2(SETTLE) : 1;
  localparam int HOLD_N = (SETTLE > 2) ? SETTLE - 3 : 0;
  localparam logic [HW-1:0] HOLD_INIT = HOLD_N[HW-1:0];
  localparam logic [CW-1:0] DEPTH_V = DEPTH[CW-1:0];
  localparam logic [7:0] MAX_V = MAX_EPOCHS[7:0];

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LOAD, S_HOLD, S_CHECK, S_EPOCH_END, S_FIN
  } state_t;

  state_t        state_q;
  logic          busy_q, done_q, conv_q, p_rst_n_q;
  logic [7:0]    epoch_q, epoch_d;
  logic [CW-1:0] err_q, run_q, ns_q;
  logic [AW-1:0] idx_q, load_addr;
  logic [HW-1:0] hold_q;
  logic [15:0]   p_word_q, p_word_d;
  logic [15:0]   mem_q [DEPTH];
  logic          wr_accept, last_sample;
`ifdef PERCEPTRON_TRAINER_ERRLOG_EN
  logic          errv_q;
  logic [AW-1:0] ferr_q, cap_q;
`endif

  assign wr_accept = wr_en && (state_q == S_IDLE);

  // NOTE: the sample table is plain storage with no reset; clearing it would
  // only add reset fan-out, and software always writes it before use.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_addr] <= wr_data;
  end

  // The next sample is index+1 after CHECK; in every other state it is
  // entry 0. A write in the same cycle as start is forwarded, so the first
  // LOAD sees the new data.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    load_addr = '0;
    if (state_q == S_CHECK) load_addr = idx_q + AW'(1);
    p_word_d = mem_q[load_addr];
    if (wr_accept && (wr_addr == load_addr)) p_word_d = wr_data;
  end

  assign epoch_d     = (epoch_q == 8'hFF) ? epoch_q : epoch_q + 8'd1;
  assign last_sample = ({1'b0, idx_q} == (ns_q - CW'(1)));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      conv_q    <= 1'b0;
      p_rst_n_q <= 1'b1;
      epoch_q   <= '0;
      err_q     <= '0;
      run_q     <= '0;
      ns_q      <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      p_word_q  <= '0;
`ifdef PERCEPTRON_TRAINER_ERRLOG_EN
      errv_q    <= 1'b0;
      ferr_q    <= '0;
      cap_q     <= '0;
`endif
    end else begin
      done_q    <= 1'b0;
      p_rst_n_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            ns_q    <= num_samples;
            epoch_q <= '0;
            err_q   <= '0;
            conv_q  <= 1'b0;
            idx_q   <= '0;
            run_q   <= '0;
`ifdef PERCEPTRON_TRAINER_ERRLOG_EN
            errv_q  <= 1'b0;
            ferr_q  <= '0;
`endif
            if ((num_samples == '0) || (num_samples > DEPTH_V)) begin
              // An unusable sample count finishes at once.
              state_q <= S_FIN;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              busy_q <= 1'b1;
              if (clear_weights) begin
                state_q   <= S_CLR;
                p_rst_n_q <= 1'b0;
              end else begin
                state_q  <= S_LOAD;
                p_word_q <= p_word_d;
              end
            end
          end
        end
        S_CLR: begin
          state_q  <= S_LOAD;
          p_word_q <= p_word_d;
        end
        S_LOAD: begin
          if (SETTLE > 2) begin
            hold_q  <= HOLD_INIT;
            state_q <= S_HOLD;
          end else begin
            state_q <= S_CHECK;
          end
        end
        S_HOLD: begin
          if (hold_q == '0) state_q <= S_CHECK;
          else              hold_q  <= hold_q - HW'(1);
        end
        S_CHECK: begin
          if (p_out != p_word_q[15]) begin
            run_q <= run_q + CW'(1);
`ifdef PERCEPTRON_TRAINER_ERRLOG_EN
            if (run_q == '0) cap_q <= idx_q;
`endif
          end
          if (last_sample) begin
            state_q <= S_EPOCH_END;
          end else begin
            idx_q    <= idx_q + AW'(1);
            state_q  <= S_LOAD;
            p_word_q <= p_word_d;
          end
        end
        S_EPOCH_END: begin
          err_q   <= run_q;
          epoch_q <= epoch_d;
          run_q   <= '0;
          idx_q   <= '0;
`ifdef PERCEPTRON_TRAINER_ERRLOG_EN
          errv_q  <= (run_q != '0);
          ferr_q  <= (run_q != '0) ? cap_q : '0;
`endif
          if (run_q == '0) begin
            conv_q  <= 1'b1;
            state_q <= S_FIN;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (epoch_d == MAX_V) begin
            conv_q  <= 1'b0;
            state_q <= S_FIN;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q  <= S_LOAD;
            p_word_q <= p_word_d;
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign converged   = conv_q;
  assign epoch_count = epoch_q;
  assign err_count   = err_q;
  assign p_rst_n     = p_rst_n_q;
  assign p_in1       = p_word_q[3:0];
  assign p_in2       = p_word_q[7:4];
  assign p_in3       = p_word_q[14:8];
  assign p_desired   = p_word_q[15];
`ifdef PERCEPTRON_TRAINER_ERRLOG_EN
  assign err_valid      = errv_q;
  assign first_err_addr = ferr_q;
`endif

endmodule

// File: tb/tb_perceptron_trainer.sv
// -----------------------------------------------------------------------------
// tb_perceptron_trainer
//
// Directed bench for perceptron_trainer (DEPTH=8, SETTLE=2, MAX_EPOCHS=3).
// A fixed stand-in perceptron drives p_out: its registered output is 1 when
// in1+in2+in3 >= 64, and p_rst_n clears it. Each record in the run table holds
// the samples and the expected results of one training run. Hand-written
// sequences then cover a write in the same cycle as start and an abort by
// reset in the middle of a run.
// -----------------------------------------------------------------------------
module tb_perceptron_trainer;

  localparam int DEPTH = 8;
  localparam int AW = 3;
  localparam int SETTLE = 2;
  localparam int MAX_EPOCHS = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [15:0]   wr_data = '0;
  logic [AW:0]   num_samples = '0;
  logic          clear_weights = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, converged;
  logic [7:0]    epoch_count;
  logic [AW:0]   err_count;
  logic [3:0]    p_in1, p_in2;
  logic [6:0]    p_in3;
  logic          p_desired, p_rst_n;
  logic          p_out;
`ifdef PERCEPTRON_TRAINER_ERRLOG_EN
  logic          err_valid;
  logic [AW-1:0] first_err_addr;
`endif

  always #5 clk = ~clk;

  perceptron_trainer #(
    .DEPTH(DEPTH), .AW(AW), .SETTLE(SETTLE), .MAX_EPOCHS(MAX_EPOCHS)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .num_samples(num_samples), .clear_weights(clear_weights), .start(start),
    .busy(busy), .done(done), .converged(converged),
    .epoch_count(epoch_count), .err_count(err_count),
`ifdef PERCEPTRON_TRAINER_ERRLOG_EN
    .err_valid(err_valid), .first_err_addr(first_err_addr),
`endif
    .p_in1(p_in1), .p_in2(p_in2), .p_in3(p_in3),
    .p_desired(p_desired), .p_rst_n(p_rst_n), .p_out(p_out)
  );

  // Stand-in perceptron with fixed weights: it never learns, so the error
  // counts in every epoch are known in advance.
  always_ff @(posedge clk or negedge p_rst_n) begin
    if (!p_rst_n) p_out <= 1'b0;
    else          p_out <= ((int'(p_in1) + int'(p_in2) + int'(p_in3)) >= 64);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mk(input int a, input int b, input int c, input bit d);
    return {d, 7'(c), 4'(b), 4'(a)};
  endfunction

  typedef struct packed {
    logic [7:0][15:0] s;     // table contents written before the run
    logic [AW:0]      num;
    logic             clr;
    logic             poke;  // issue start + wr_en in the middle of the run
    int               cyc;   // cycle after start in which done is high
    logic             conv;
    logic [7:0]       ep;
    logic [AW:0]      err;
    logic             ev;
    logic [AW-1:0]    fa;
    logic [15:0]      last;  // perceptron input word left on p_in* after the run
  } run_t;

  run_t runs [7];

  task automatic run_one(input run_t r, input int k);
    int  n;
    int  lows;
    bit  got;
    logic b1;
    string t;
    t = $sformatf("run%0d", k);
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = r.s[i];
      @(negedge clk);
    end
    wr_en = 1'b0;
    num_samples = r.num; clear_weights = r.clr; start = 1'b1;
    @(negedge clk);
    n = 1; lows = 0; got = 1'b0; b1 = busy;
    while (n <= 200) begin
      start   = r.poke && (n == 5);
      wr_en   = r.poke && (n == 5);
      wr_addr = 3'd1;
      wr_data = 16'hFFFF;
      if (p_rst_n === 1'b0) lows++;
      if (done === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
      n++;
    end
    start = 1'b0; wr_en = 1'b0;
    check({t, " done_seen"}, 32'(got), 32'd1);
    check({t, " done_cycle"}, n, r.cyc);
    check({t, " p_rst_n_low_cycles"}, lows, 32'(r.clr));
    check({t, " busy_first_cycle"}, 32'(b1), 32'(r.cyc > 1));
    check({t, " converged"}, 32'(converged), 32'(r.conv));
    check({t, " epoch_count"}, 32'(epoch_count), 32'(r.ep));
    check({t, " err_count"}, 32'(err_count), 32'(r.err));
`ifdef PERCEPTRON_TRAINER_ERRLOG_EN
    check({t, " err_valid"}, 32'(err_valid), 32'(r.ev));
    check({t, " first_err_addr"}, 32'(first_err_addr), 32'(r.fa));
`endif
    @(negedge clk);
    check({t, " done_one_cycle"}, 32'(done), 32'd0);
    check({t, " busy_after"}, 32'(busy), 32'd0);
    check({t, " p_word_held"}, 32'({p_desired, p_in3, p_in2, p_in1}), 32'(r.last));
    check({t, " converged_held"}, 32'(converged), 32'(r.conv));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int dones;
    bit got;

    // Run table: samples and expected results, worked out by hand.
    for (int i = 0; i < 7; i++) runs[i] = '0;
    // 0: separable, clear_weights -> CLR + 4*2 + EPOCH_END, converges in one epoch
    runs[0].s[0] = mk(15, 15, 127, 1); runs[0].s[1] = mk(0, 0, 0, 0);
    runs[0].s[2] = mk(10, 10, 100, 1); runs[0].s[3] = mk(1, 2, 3, 0);
    runs[0].num = 4; runs[0].clr = 1; runs[0].cyc = 11; runs[0].conv = 1;
    runs[0].ep = 1; runs[0].err = 0; runs[0].last = mk(1, 2, 3, 0);
    // 1: contradictory pair, epoch limit 3; a start and a write are issued mid-run
    runs[1].s[0] = mk(5, 5, 5, 1); runs[1].s[1] = mk(5, 5, 5, 0);
    runs[1].num = 2; runs[1].poke = 1; runs[1].cyc = 16; runs[1].conv = 0;
    runs[1].ep = 3; runs[1].err = 1; runs[1].ev = 1; runs[1].fa = 0;
    runs[1].last = mk(5, 5, 5, 0);
    // 2: samples 2 and 3 misclassified, so the first error is at index 2
    runs[2].s[0] = mk(15, 15, 127, 1); runs[2].s[1] = mk(0, 0, 0, 0);
    runs[2].s[2] = mk(1, 1, 1, 1);     runs[2].s[3] = mk(15, 15, 127, 0);
    runs[2].num = 4; runs[2].cyc = 28; runs[2].conv = 0; runs[2].ep = 3;
    runs[2].err = 2; runs[2].ev = 1; runs[2].fa = 2; runs[2].last = mk(15, 15, 127, 0);
    // 3: num_samples = 0 -> immediate done, outputs cleared, p_in* unchanged
    runs[3].num = 0; runs[3].clr = 0; runs[3].cyc = 1; runs[3].last = mk(15, 15, 127, 0);
    // 4: num_samples = 9 > DEPTH -> immediate done
    runs[4].num = 9; runs[4].cyc = 1; runs[4].last = mk(15, 15, 127, 0);
    // 5: single sample, converges
    runs[5].s[0] = mk(15, 15, 127, 1);
    runs[5].num = 1; runs[5].cyc = 4; runs[5].conv = 1; runs[5].ep = 1;
    runs[5].last = mk(15, 15, 127, 1);
    // 6: full table (num = DEPTH) with clear_weights
    runs[6].s[0] = mk(15, 15, 127, 1); runs[6].s[1] = mk(0, 0, 0, 0);
    runs[6].s[2] = mk(10, 10, 100, 1); runs[6].s[3] = mk(1, 2, 3, 0);
    runs[6].s[4] = mk(0, 0, 0, 0);     runs[6].s[5] = mk(15, 0, 127, 1);
    runs[6].s[6] = mk(3, 3, 3, 0);     runs[6].s[7] = mk(8, 8, 60, 1);
    runs[6].num = 8; runs[6].clr = 1; runs[6].cyc = 19; runs[6].conv = 1;
    runs[6].ep = 1; runs[6].last = mk(8, 8, 60, 1);

    // Reset values
    repeat (2) @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst converged", 32'(converged), 32'd0);
    check("rst epoch_count", 32'(epoch_count), 32'd0);
    check("rst err_count", 32'(err_count), 32'd0);
    check("rst p_word", 32'({p_desired, p_in3, p_in2, p_in1}), 32'd0);
    check("rst p_rst_n", 32'(p_rst_n), 32'd1);
`ifdef PERCEPTRON_TRAINER_ERRLOG_EN
    check("rst err_valid", 32'(err_valid), 32'd0);
    check("rst first_err_addr", 32'(first_err_addr), 32'd0);
`endif
    reset = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 7; k++) run_one(runs[k], k);

    // A write in the same cycle as start: the first LOAD sees the new word
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = mk(7, 3, 99, 1);
    num_samples = 1; clear_weights = 1'b0; start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    check("fwd p_in1", 32'(p_in1), 32'd7);
    check("fwd p_in2", 32'(p_in2), 32'd3);
    check("fwd p_in3", 32'(p_in3), 32'd99);
    check("fwd p_desired", 32'(p_desired), 32'd1);
    n = 1; got = 1'b0;
    while (n <= 50) begin
      if (done === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
      n++;
    end
    check("fwd done_cycle", n, 4);
    check("fwd converged", 32'(converged), 32'd1);
    @(negedge clk);

    // Reset in the middle of a sample window aborts the run with no done pulse
    num_samples = 2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("abort busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort p_rst_n", 32'(p_rst_n), 32'd1);
    check("abort p_word", 32'({p_desired, p_in3, p_in2, p_in1}), 32'd0);
    check("abort converged", 32'(converged), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    check("abort done_pulses", dones, 0);
    check("abort busy_after", 32'(busy), 32'd0);
    check("abort epoch_count", 32'(epoch_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
